// File: rtl/mem_tile_sram_arb.sv
// Round-robin arbiter letting several OBI-style requesters share one single-port SRAM,
// with an optional zero-fill pass over the whole array after reset.
module mem_tile_sram_arb #(
   parameter int NumPorts   = 2,
   parameter int AddrWidth  = 48,
   parameter int DataWidth  = 512,
   parameter int NumWords   = 4096,
   parameter bit InitEnable = 1'b1,
   localparam int MemAddrWidth = $clog2(NumWords),
   localparam int BeWidth      = DataWidth / 8
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [NumPorts-1:0]            req_i,
   output logic [NumPorts-1:0]            gnt_o,
   input  logic [NumPorts-1:0]            we_i,
   input  logic [NumPorts*AddrWidth-1:0]  addr_i,
   input  logic [NumPorts*DataWidth-1:0]  wdata_i,
   input  logic [NumPorts*BeWidth-1:0]    be_i,
   output logic [NumPorts-1:0]            rvalid_o,
   output logic [NumPorts*DataWidth-1:0]  rdata_o,
   output logic                           mem_req_o,
   output logic                           mem_we_o,
   output logic [MemAddrWidth-1:0]        mem_addr_o,
   output logic [DataWidth-1:0]           mem_wdata_o,
   output logic [BeWidth-1:0]             mem_be_o,
   input  logic                           mem_gnt_i,
   input  logic [DataWidth-1:0]           mem_rdata_i,
   output logic                           init_done_o
);

   localparam int ByteOffset   = $clog2(DataWidth / 8);
   localparam int PortIdxWidth = (NumPorts > 1) ? $clog2(NumPorts) : 1;

   typedef enum logic {INIT, RUN} state_t;

   state_t                  state_reg, state_next;
   logic [MemAddrWidth-1:0] init_cnt_reg, init_cnt_next;
   logic [PortIdxWidth-1:0] ptr_reg, ptr_next;
   logic                    rsp_valid_reg, rsp_valid_next;
   logic                    rsp_read_reg, rsp_read_next;
   logic [PortIdxWidth-1:0] rsp_port_reg, rsp_port_next;

   logic [MemAddrWidth-1:0] port_addr  [NumPorts];
   logic [DataWidth-1:0]    port_wdata [NumPorts];
   logic [BeWidth-1:0]      port_be    [NumPorts];

   logic                    win_valid;
   logic [PortIdxWidth-1:0] win_idx;

   // Only the word-index slice of each byte address matters; upper bits wrap.
   logic addr_unused;
   assign addr_unused = ^addr_i;

   genvar gi;
   generate
      for (gi = 0; gi < NumPorts; gi++) begin : g_port
         assign port_addr[gi]  = addr_i[gi*AddrWidth + ByteOffset +: MemAddrWidth];
         assign port_wdata[gi] = wdata_i[gi*DataWidth +: DataWidth];
         assign port_be[gi]    = be_i[gi*BeWidth +: BeWidth];
         assign rvalid_o[gi]   = !rst_i && rsp_valid_reg && (rsp_port_reg == PortIdxWidth'(gi));
         assign rdata_o[gi*DataWidth +: DataWidth] =
            (rvalid_o[gi] && rsp_read_reg) ? mem_rdata_i : '0;
      end
   endgenerate

   // Two passes: first the ports at or above the pointer, then wrap to the bottom.
   always_comb begin
      win_valid = 1'b0;
      win_idx   = '0;
      for (int p = 0; p < NumPorts; p++) begin
         if (!win_valid && req_i[p] && (p >= int'(ptr_reg))) begin
            win_valid = 1'b1;
            win_idx   = PortIdxWidth'(p);
         end
      end
      for (int p = 0; p < NumPorts; p++) begin
         if (!win_valid && req_i[p]) begin
            win_valid = 1'b1;
            win_idx   = PortIdxWidth'(p);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg     <= InitEnable ? INIT : RUN;
         init_cnt_reg  <= '0;
         ptr_reg       <= '0;
         rsp_valid_reg <= 1'b0;
         rsp_read_reg  <= 1'b0;
         rsp_port_reg  <= '0;
      end else begin
         state_reg     <= state_next;
         init_cnt_reg  <= init_cnt_next;
         ptr_reg       <= ptr_next;
         rsp_valid_reg <= rsp_valid_next;
         rsp_read_reg  <= rsp_read_next;
         rsp_port_reg  <= rsp_port_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      init_cnt_next  = init_cnt_reg;
      ptr_next       = ptr_reg;
      rsp_valid_next = 1'b0;
      rsp_read_next  = 1'b0;
      rsp_port_next  = rsp_port_reg;
      gnt_o          = '0;
      mem_req_o      = 1'b0;
      mem_we_o       = 1'b0;
      mem_addr_o     = '0;
      mem_wdata_o    = '0;
      mem_be_o       = '0;

      case (state_reg)
         INIT: begin
            mem_req_o  = 1'b1;
            mem_we_o   = 1'b1;
            mem_be_o   = '1;
            mem_addr_o = init_cnt_reg;
            if (mem_gnt_i) begin
               if (init_cnt_reg == MemAddrWidth'(NumWords - 1)) begin
                  state_next = RUN;
               end else begin
                  init_cnt_next = init_cnt_reg + MemAddrWidth'(1);
               end
            end
         end
         RUN: begin
            mem_req_o = |req_i;
            if (win_valid) begin
               mem_we_o    = we_i[win_idx];
               mem_addr_o  = port_addr[win_idx];
               mem_wdata_o = port_wdata[win_idx];
               mem_be_o    = port_be[win_idx];
               if (mem_gnt_i) begin
                  gnt_o[win_idx] = 1'b1;
                  ptr_next       = (win_idx == PortIdxWidth'(NumPorts - 1)) ?
                                   '0 : win_idx + PortIdxWidth'(1);
                  rsp_valid_next = 1'b1;
                  rsp_read_next  = !we_i[win_idx];
                  rsp_port_next  = win_idx;
               end
            end
         end
         default: state_next = INIT;
      endcase

      if (rst_i) begin
         gnt_o     = '0;
         mem_req_o = 1'b0;
         mem_we_o  = 1'b0;
      end
   end

   assign init_done_o = !rst_i && (state_reg == RUN);

endmodule

// File: tb/tb_mem_tile_sram_arb.sv
// Bench for mem_tile_sram_arb: a per-cycle reference model of the arbitration rules
// plus directed scenarios with hand-computed expectations.
module tb_mem_tile_sram_arb;

   logic         clk = 1'b0;
   logic         rst;
   logic [1:0]   req, gnt, we, rvalid;
   logic [31:0]  addr;
   logic [127:0] wdata, rdata;
   logic [15:0]  be;
   logic         mem_req, mem_we, mem_gnt, init_done;
   logic [3:0]   mem_addr;
   logic [63:0]  mem_wdata, mem_rdata;
   logic [7:0]   mem_be;

   int n_cmp = 0;
   int n_bad = 0;
   int done_c;

   mem_tile_sram_arb #(
      .NumPorts(2), .AddrWidth(16), .DataWidth(64), .NumWords(16), .InitEnable(1'b1)
   ) dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .we_i(we), .addr_i(addr),
      .wdata_i(wdata), .be_i(be), .rvalid_o(rvalid), .rdata_o(rdata),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_gnt_i(mem_gnt),
      .mem_rdata_i(mem_rdata), .init_done_o(init_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: INIT sweeps words 0..15, RUN picks the first requester
   // counting up from the pointer; each grant yields one response next cycle.
   typedef struct {int port; bit rd;} rsp_t;
   rsp_t m_rsp_q[$];
   bit   m_init = 1'b1;
   int   m_cnt = 0;
   int   m_ptr = 0;

   always @(negedge clk) begin : model_chk
      rsp_t         due;
      bit           has_due;
      int           w, p;
      logic [1:0]   e_gnt, e_rv;
      logic [127:0] e_rd;
      logic [15:0]  a;
      has_due = (m_rsp_q.size() > 0);
      if (has_due) due = m_rsp_q.pop_front();
      if (rst) begin
         chk("rst_gnt", gnt, 0);
         chk("rst_rvalid", rvalid, 0);
         chk("rst_rdata", rdata, 0);
         chk("rst_mem_req", mem_req, 0);
         chk("rst_mem_we", mem_we, 0);
         chk("rst_init_done", init_done, 0);
         m_init = 1'b1;
         m_cnt  = 0;
         m_ptr  = 0;
         m_rsp_q.delete();
      end else begin
         e_rv = 2'b00;
         e_rd = '0;
         if (has_due) begin
            e_rv[due.port] = 1'b1;
            if (due.rd) e_rd[due.port*64 +: 64] = mem_rdata;
         end
         chk("m_rvalid", rvalid, e_rv);
         chk("m_rdata", rdata, e_rd);
         chk("m_init_done", init_done, !m_init);
         if (m_init) begin
            chk("m_init_req", mem_req, 1);
            chk("m_init_we", mem_we, 1);
            chk("m_init_addr", mem_addr, m_cnt);
            chk("m_init_wdata", mem_wdata, 0);
            chk("m_init_be", mem_be, 8'hFF);
            chk("m_init_gnt", gnt, 0);
            if (mem_gnt) begin
               if (m_cnt == 15) m_init = 1'b0;
               else m_cnt++;
            end
         end else begin
            w = -1;
            for (int k = 0; k < 2; k++) begin
               p = (m_ptr + k) % 2;
               if (w < 0 && req[p]) w = p;
            end
            chk("m_mem_req", mem_req, req != 2'b00);
            e_gnt = 2'b00;
            if (w >= 0) begin
               a = addr[w*16 +: 16];
               chk("m_mem_we", mem_we, we[w]);
               chk("m_mem_addr", mem_addr, (a >> 3) & 16'hF);
               chk("m_mem_wdata", mem_wdata, wdata[w*64 +: 64]);
               chk("m_mem_be", mem_be, be[w*8 +: 8]);
               if (mem_gnt) begin
                  e_gnt[w] = 1'b1;
                  m_ptr = (w + 1) % 2;
                  m_rsp_q.push_back('{port: w, rd: !we[w]});
               end
            end
            chk("m_gnt", gnt, e_gnt);
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; req = 2'b00; we = 2'b00; addr = '0; wdata = '0; be = '0;
      mem_gnt = 1'b1; mem_rdata = '0;
      next_cycle();
      @(negedge clk);
      chk("reset_init_done", init_done, 0);
      chk("reset_rvalid", rvalid, 0);
      next_cycle();

      // Full zero-fill with both ports requesting throughout.
      rst = 1'b0; req = 2'b11;
      done_c = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (init_done) begin
            done_c = c;
            break;
         end
         chk("init_gnt_zero", gnt, 0);
         next_cycle();
      end
      chk("init_done_cycle", done_c, 17);
      next_cycle();
      req = 2'b00;

      // Restart INIT and stall three cycles at word 5.
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      done_c = 0;
      for (int c = 1; c <= 40; c++) begin
         mem_gnt = (c >= 6 && c <= 8) ? 1'b0 : 1'b1;
         @(negedge clk);
         if (init_done) begin
            done_c = c;
            break;
         end
         if (c >= 6 && c <= 8) chk("stall_init_addr", mem_addr, 5);
         next_cycle();
      end
      chk("stall_done_cycle", done_c, 20);
      next_cycle();

      // Both ports reading back to back: grants alternate.
      mem_gnt = 1'b1; req = 2'b11; we = 2'b00; addr = {16'h0020, 16'h0010};
      for (int c = 0; c < 5; c++) begin
         if (c == 4) req = 2'b00;
         mem_rdata = 64'h1111_0000_0000_0000 + 64'(c);
         @(negedge clk);
         if (c < 4) chk("rr_gnt", gnt, (c % 2 == 0) ? 2'b01 : 2'b10);
         if (c > 0) chk("rr_rvalid", rvalid, (c % 2 == 1) ? 2'b01 : 2'b10);
         next_cycle();
      end

      // Port 1 writes then reads byte address 0x48 (word 9).
      req = 2'b10; we = 2'b10; addr[31:16] = 16'h0048;
      wdata[127:64] = 64'hDEAD_BEEF; be[15:8] = 8'h0F;
      mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      @(negedge clk);
      chk("wr_addr", mem_addr, 9);
      chk("wr_gnt", gnt, 2'b10);
      chk("wr_we", mem_we, 1);
      chk("wr_be", mem_be, 8'h0F);
      chk("wr_wdata", mem_wdata, 64'hDEAD_BEEF);
      next_cycle();
      we = 2'b00;
      @(negedge clk);
      chk("wr_rvalid", rvalid, 2'b10);
      chk("wr_rdata_zero", rdata[127:64], 0);
      chk("rd_addr", mem_addr, 9);
      chk("rd_gnt", gnt, 2'b10);
      chk("rd_we", mem_we, 0);
      next_cycle();
      req = 2'b00; mem_rdata = 64'h0123_4567_89AB_CDEF;
      @(negedge clk);
      chk("rd_rvalid", rvalid, 2'b10);
      chk("rd_rdata", rdata[127:64], 64'h0123_4567_89AB_CDEF);
      chk("rd_rdata_p0", rdata[63:0], 0);
      next_cycle();

      // Port 0 read stalled by the SRAM for two cycles.
      req = 2'b01; we = 2'b00; addr[15:0] = 16'h0018; mem_gnt = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("stall_gnt", gnt, 0);
         chk("stall_rvalid", rvalid, 0);
         chk("stall_mem_req", mem_req, 1);
         next_cycle();
      end
      mem_gnt = 1'b1;
      @(negedge clk);
      chk("unstall_gnt", gnt, 2'b01);
      chk("unstall_rvalid", rvalid, 0);
      next_cycle();
      req = 2'b11;
      @(negedge clk);
      chk("ptr_after_p0_gnt", gnt, 2'b10);
      chk("unstall_rsp", rvalid, 2'b01);
      next_cycle();

      // Reset landing on a grant cycle.
      req = 2'b01; rst = 1'b1;
      @(negedge clk);
      chk("rst_grant_gnt", gnt, 0);
      next_cycle();
      rst = 1'b0; req = 2'b00;
      @(negedge clk);
      chk("post_rst_rvalid", rvalid, 0);
      chk("post_rst_init_done", init_done, 0);
      chk("post_rst_addr", mem_addr, 0);
      chk("post_rst_we", mem_we, 1);
      next_cycle();
      @(negedge clk);
      chk("post_rst_addr1", mem_addr, 1);
      next_cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
